voice_phase_scheduler: RTL and testbench

//   Time-multiplexes a single phase-accumulate datapath across NUM_VOICES synth voices.

---
 rtl/voice_phase_scheduler.sv | 202 ++++++++++++++++++++
 tb/tb_voice_phase_scheduler.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/voice_phase_scheduler.sv
// Voice allocator plus a time-multiplexed phase accumulator.
// A sample tick sweeps every voice once and emits one updated phase per cycle.
module voice_phase_scheduler #(
   parameter int WORD_BITS  = 32,
   parameter int NUM_VOICES = 8,
   parameter int NOTE_BITS  = 7,
   localparam int VW        = $clog2(NUM_VOICES)
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  sample_tick_i,
   input  logic                  note_valid_i,
   output logic                  note_ready_o,
   input  logic                  note_on_i,
   input  logic [NOTE_BITS-1:0]  note_id_i,
   input  logic [WORD_BITS-1:0]  phase_inc_i,
   output logic                  phase_valid_o,
   output logic [VW-1:0]         voice_o,
   output logic [WORD_BITS-1:0]  phase_o,
   output logic                  gate_o,
   output logic                  frame_done_o,
   output logic [NUM_VOICES-1:0] voice_active_o,
   output logic                  overrun_o
);

   localparam logic [0:0]    ST_IDLE    = 1'b0;
   localparam logic [0:0]    ST_SWEEP   = 1'b1;
   localparam logic [VW-1:0] LAST_VOICE = VW'(NUM_VOICES - 1);

   logic [0:0]            state_q, state_d;
   logic [VW-1:0]         cnt_q, cnt_d;
   logic [VW-1:0]         steal_q, steal_d;
   logic [WORD_BITS-1:0]  phase_q [NUM_VOICES];
   logic [WORD_BITS-1:0]  phase_d [NUM_VOICES];
   logic [WORD_BITS-1:0]  inc_q   [NUM_VOICES];
   logic [WORD_BITS-1:0]  inc_d   [NUM_VOICES];
   logic [NOTE_BITS-1:0]  note_q  [NUM_VOICES];
   logic [NOTE_BITS-1:0]  note_d  [NUM_VOICES];
   logic [NUM_VOICES-1:0] active_q, active_d;

   logic                  out_valid_q, out_valid_d;
   logic [VW-1:0]         out_voice_q, out_voice_d;
   logic [WORD_BITS-1:0]  out_phase_q, out_phase_d;
   logic                  out_gate_q, out_gate_d;
   logic                  frame_done_q, frame_done_d;
   logic                  overrun_q, overrun_d;

   logic                  accept;
   logic                  hit, free;
   logic [VW-1:0]         hit_idx, free_idx, tgt_idx;
   logic                  issue_en;
   logic [VW-1:0]         issue_idx;
   logic [WORD_BITS-1:0]  phase_nx;

   // Inactive voices are parked at phase 0 so a later allocation starts clean.
   function automatic logic [WORD_BITS-1:0] next_phase(
      input logic [WORD_BITS-1:0] ph,
      input logic [WORD_BITS-1:0] inc,
      input logic                 act
   );
      return act ? (ph + inc) : '0;
   endfunction

   // Downward scan leaves the lowest matching index in each result.
   always_comb begin
      hit      = 1'b0;
      hit_idx  = '0;
      free     = 1'b0;
      free_idx = '0;
      for (int v = NUM_VOICES - 1; v >= 0; v--) begin
         if (active_q[v] && (note_q[v] == note_id_i)) begin
            hit     = 1'b1;
            hit_idx = VW'(v);
         end
         if (!active_q[v]) begin
            free     = 1'b1;
            free_idx = VW'(v);
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      steal_d      = steal_q;
      phase_d      = phase_q;
      inc_d        = inc_q;
      note_d       = note_q;
      active_d     = active_q;
      overrun_d    = overrun_q;
      out_valid_d  = 1'b0;
      out_voice_d  = '0;
      out_phase_d  = '0;
      out_gate_d   = 1'b0;
      frame_done_d = 1'b0;
      tgt_idx      = '0;
      issue_en     = 1'b0;
      issue_idx    = '0;
      phase_nx     = '0;
      accept       = note_valid_i && (state_q == ST_IDLE);

      if (accept) begin
         if (note_on_i) begin
            if (hit) begin
               tgt_idx = hit_idx;
            end else if (free) begin
               tgt_idx = free_idx;
            end else begin
               tgt_idx = steal_q;
               steal_d = steal_q + VW'(1);
            end
            phase_d[tgt_idx]  = '0;
            inc_d[tgt_idx]    = phase_inc_i;
            note_d[tgt_idx]   = note_id_i;
            active_d[tgt_idx] = 1'b1;
         end else begin
            for (int v = 0; v < NUM_VOICES; v++) begin
               if (active_q[v] && (note_q[v] == note_id_i)) begin
                  active_d[v] = 1'b0;
                  phase_d[v]  = '0;
               end
            end
         end
      end

      case (state_q)
         ST_IDLE: begin
            if (sample_tick_i) begin
               issue_en  = 1'b1;
               issue_idx = '0;
               state_d   = ST_SWEEP;
            end
         end
         ST_SWEEP: begin
            if (sample_tick_i) overrun_d = 1'b1;
            if (cnt_q == LAST_VOICE) begin
               state_d = ST_IDLE;
            end else begin
               issue_en  = 1'b1;
               issue_idx = cnt_q + VW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Sweep reads the post-note view, so a same-edge accept is already visible.
      if (issue_en) begin
         phase_nx           = next_phase(phase_d[issue_idx], inc_d[issue_idx], active_d[issue_idx]);
         phase_d[issue_idx] = phase_nx;
         cnt_d              = issue_idx;
         out_valid_d        = 1'b1;
         out_voice_d        = issue_idx;
         out_phase_d        = phase_nx;
         out_gate_d         = active_d[issue_idx];
         frame_done_d       = (issue_idx == LAST_VOICE);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         steal_q      <= '0;
         active_q     <= '0;
         out_valid_q  <= 1'b0;
         out_voice_q  <= '0;
         out_phase_q  <= '0;
         out_gate_q   <= 1'b0;
         frame_done_q <= 1'b0;
         overrun_q    <= 1'b0;
         for (int v = 0; v < NUM_VOICES; v++) begin
            phase_q[v] <= '0;
            inc_q[v]   <= '0;
            note_q[v]  <= '0;
         end
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         steal_q      <= steal_d;
         active_q     <= active_d;
         out_valid_q  <= out_valid_d;
         out_voice_q  <= out_voice_d;
         out_phase_q  <= out_phase_d;
         out_gate_q   <= out_gate_d;
         frame_done_q <= frame_done_d;
         overrun_q    <= overrun_d;
         phase_q      <= phase_d;
         inc_q        <= inc_d;
         note_q       <= note_d;
      end
   end

   assign note_ready_o   = (state_q == ST_IDLE);
   assign phase_valid_o  = out_valid_q;
   assign voice_o        = out_voice_q;
   assign phase_o        = out_phase_q;
   assign gate_o         = out_gate_q;
   assign frame_done_o   = frame_done_q;
   assign voice_active_o = active_q;
   assign overrun_o      = overrun_q;

endmodule

// File: tb/tb_voice_phase_scheduler.sv
// Bench for voice_phase_scheduler: directed scenarios plus random note/tick traffic
// checked against a per-voice array model of the allocation and accumulation rules.
module tb_voice_phase_scheduler;

   localparam int NV = 8;
   localparam int WB = 32;
   localparam int NB = 7;

   logic          clk = 1'b0;
   logic          rst_i;
   logic          sample_tick_i;
   logic          note_valid_i;
   logic          note_ready_o;
   logic          note_on_i;
   logic [NB-1:0] note_id_i;
   logic [WB-1:0] phase_inc_i;
   logic          phase_valid_o;
   logic [2:0]    voice_o;
   logic [WB-1:0] phase_o;
   logic          gate_o;
   logic          frame_done_o;
   logic [NV-1:0] voice_active_o;
   logic          overrun_o;

   always #5 clk = ~clk;

   voice_phase_scheduler #(.WORD_BITS(WB), .NUM_VOICES(NV), .NOTE_BITS(NB)) dut (
      .clk_i          (clk),
      .rst_i          (rst_i),
      .sample_tick_i  (sample_tick_i),
      .note_valid_i   (note_valid_i),
      .note_ready_o   (note_ready_o),
      .note_on_i      (note_on_i),
      .note_id_i      (note_id_i),
      .phase_inc_i    (phase_inc_i),
      .phase_valid_o  (phase_valid_o),
      .voice_o        (voice_o),
      .phase_o        (phase_o),
      .gate_o         (gate_o),
      .frame_done_o   (frame_done_o),
      .voice_active_o (voice_active_o),
      .overrun_o      (overrun_o)
   );

   int n_chk = 0;
   int n_err = 0;

   // Reference state: one entry per voice slot.
   logic [WB-1:0] m_phase [NV];
   logic [WB-1:0] m_inc   [NV];
   logic [NB-1:0] m_id    [NV];
   logic [NV-1:0] m_act;
   int            m_steal;
   logic          m_ovr;
   logic [WB-1:0] last_ph [NV];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic void m_reset();
      for (int v = 0; v < NV; v++) begin
         m_phase[v] = '0;
         m_inc[v]   = '0;
         m_id[v]    = '0;
      end
      m_act   = '0;
      m_steal = 0;
      m_ovr   = 1'b0;
   endfunction

   function automatic void m_note(input logic on, input logic [NB-1:0] id, input logic [WB-1:0] inc);
      int tgt;
      tgt = -1;
      if (on) begin
         for (int v = 0; v < NV; v++) if (tgt < 0 && m_act[v] && m_id[v] == id) tgt = v;
         for (int v = 0; v < NV; v++) if (tgt < 0 && !m_act[v]) tgt = v;
         if (tgt < 0) begin
            tgt     = m_steal;
            m_steal = (m_steal + 1) % NV;
         end
         m_phase[tgt] = '0;
         m_inc[tgt]   = inc;
         m_id[tgt]    = id;
         m_act[tgt]   = 1'b1;
      end else begin
         for (int v = 0; v < NV; v++) begin
            if (m_act[v] && m_id[v] == id) begin
               m_act[v]   = 1'b0;
               m_phase[v] = '0;
            end
         end
      end
   endfunction

   task automatic check_quiet(input string tag);
      chk({tag, "_valid"}, phase_valid_o, 0);
      chk({tag, "_voice"}, voice_o, 0);
      chk({tag, "_phase"}, phase_o, 0);
      chk({tag, "_gate"}, gate_o, 0);
      chk({tag, "_fdone"}, frame_done_o, 0);
      chk({tag, "_ready"}, note_ready_o, 1);
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      step();
      rst_i = 1'b0;
      m_reset();
   endtask

   task automatic send_note(input logic on, input logic [NB-1:0] id, input logic [WB-1:0] inc);
      note_on_i    = on;
      note_id_i    = id;
      phase_inc_i  = inc;
      note_valid_i = 1'b1;
      step();
      note_valid_i = 1'b0;
      m_note(on, id, inc);
      chk("note_active", voice_active_o, m_act);
   endtask

   // One full sweep; optionally raise note_valid, a stray tick, or reset at sweep cycle k.
   task automatic sweep(input int hold_at, input int tick_at, input int rst_at);
      logic [WB-1:0] exp;
      chk("tick_cycle_valid", phase_valid_o, 0);
      sample_tick_i = 1'b1;
      step();
      sample_tick_i = 1'b0;
      for (int k = 0; k < NV; k++) begin
         exp = m_act[k] ? (m_phase[k] + m_inc[k]) : '0;
         m_phase[k] = exp;
         last_ph[k] = exp;
         chk("sw_valid", phase_valid_o, 1);
         chk("sw_voice", voice_o, k);
         chk("sw_gate", gate_o, m_act[k]);
         chk("sw_phase", phase_o, exp);
         chk("sw_fdone", frame_done_o, (k == NV - 1));
         chk("sw_ready", note_ready_o, 0);
         chk("sw_ovr", overrun_o, m_ovr);
         sample_tick_i = (k == tick_at);
         if (k == tick_at) m_ovr = 1'b1;
         if (k == hold_at) note_valid_i = 1'b1;
         if (k == rst_at) begin
            rst_i = 1'b1;
            step();
            rst_i         = 1'b0;
            sample_tick_i = 1'b0;
            m_reset();
            check_quiet("rst_mid");
            chk("rst_mid_active", voice_active_o, 0);
            chk("rst_mid_ovr", overrun_o, 0);
            return;
         end
         step();
      end
      sample_tick_i = 1'b0;
      chk("post_valid", phase_valid_o, 0);
      chk("post_fdone", frame_done_o, 0);
      chk("post_ready", note_ready_o, 1);
      chk("post_ovr", overrun_o, m_ovr);
      chk("post_active", voice_active_o, m_act);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog expired (t=%0t)", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [WB-1:0] inc9;
      int            r;
      rst_i         = 1'b1;
      sample_tick_i = 1'b0;
      note_valid_i  = 1'b0;
      note_on_i     = 1'b0;
      note_id_i     = '0;
      phase_inc_i   = '0;
      step();
      step();
      check_quiet("reset");
      chk("reset_active", voice_active_o, 0);
      chk("reset_ovr", overrun_o, 0);
      rst_i = 1'b0;
      m_reset();

      // Single voice accumulation
      send_note(1'b1, 7'd60, 32'h0100_0000);
      for (int i = 1; i <= 3; i++) begin
         sweep(-1, -1, -1);
         chk("single_v0", last_ph[0], 32'h0100_0000 * i);
         chk("single_v1", last_ph[1], 0);
      end

      // Wraparound
      do_reset();
      send_note(1'b1, 7'd60, 32'hC000_0000);
      sweep(-1, -1, -1);
      chk("wrap_1", last_ph[0], 32'hC000_0000);
      sweep(-1, -1, -1);
      chk("wrap_2", last_ph[0], 32'h8000_0000);

      // Allocation, stealing and note-off
      do_reset();
      for (int i = 0; i < NV; i++) send_note(1'b1, NB'(i), $urandom | 32'h1);
      chk("alloc_full", voice_active_o, 8'hFF);
      inc9 = $urandom;
      send_note(1'b1, 7'd9, inc9);
      send_note(1'b1, 7'd10, 32'h0000_0777);
      sweep(-1, -1, -1);
      chk("steal_v0", last_ph[0], inc9);
      chk("steal_v1", last_ph[1], 32'h0000_0777);
      send_note(1'b0, 7'd3, '0);
      chk("off_3", voice_active_o, 8'hF7);
      send_note(1'b0, 7'd99, '0);
      chk("off_99", voice_active_o, 8'hF7);
      sweep(-1, -1, -1);
      chk("off_v3_phase", last_ph[3], 0);

      // Retrigger requested mid-sweep, held off until IDLE
      note_on_i   = 1'b1;
      note_id_i   = 7'd5;
      phase_inc_i = 32'h10;
      sweep(2, -1, -1);
      step();
      note_valid_i = 1'b0;
      m_note(1'b1, 7'd5, 32'h10);
      chk("retrig_active", voice_active_o, 8'hF7);
      sweep(-1, -1, -1);
      chk("retrig_v5", last_ph[5], 32'h10);

      // Overrun, then reset mid-sweep
      sweep(-1, 3, -1);
      chk("overrun_sticky", overrun_o, 1);
      sweep(-1, -1, -1);
      chk("overrun_still", overrun_o, 1);
      sweep(-1, -1, 4);

      // Random traffic
      for (int it = 0; it < 80; it++) begin
         r = $urandom_range(0, 4);
         if (r <= 1) send_note(1'b1, NB'($urandom_range(0, 11)), $urandom);
         else if (r == 2) send_note(1'b0, NB'($urandom_range(0, 11)), $urandom);
         else sweep(-1, ($urandom_range(0, 9) == 0) ? 5 : -1, -1);
      end

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
